// File: rtl/la_serializer_pkg.sv
// Shared definitions for the la_serializer / la_deserializer link pair.
package la_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Beat-counter width for a given number of beats per word, never below 1.
  function automatic int unsigned cw_of(input int unsigned beats);
    int unsigned w;
    w = 1;
    if (beats > 32'd1) begin
      w = $clog2(beats);
    end
    return w;
  endfunction

endpackage

// File: rtl/la_serializer_cnt.sv
// Beat counter with clear, enable and terminal-count decode.
module la_serializer_cnt
  import la_serializer_pkg::*;
#(
  parameter int unsigned BEATS = 4,
  parameter int unsigned CW    = cw_of(BEATS)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 32'd1);

  logic [CW-1:0] count_q;

  // Clear wins over enable; the count wraps to zero after the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tc ? '0 : count_q + 1'b1;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/la_serializer.sv
// Parallel-to-serial transmitter: one DW-bit word out as DW/SW beats of SW bits.
module la_serializer
  import la_serializer_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned SW       = 1,
  parameter int unsigned MSBFIRST = 0,
  parameter              PROP     = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [SW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int unsigned BEATS = DW / SW;
  localparam int unsigned CW    = cw_of(BEATS);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] sr_q;
  logic          tc;
  logic          accept;
  logic          xfer;

  // PROP is an implementation hint only; no variant changes behaviour here.
  if (PROP == "") begin : g_prop_none
  end

  la_serializer_cnt #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (xfer),
    .tc    (tc)
  );

  // Ready when idle, or when the final beat leaves this cycle (back-to-back accept).
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state_q == IDLE) || ((state_q == SHIFT) && tc && out_ready);
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SHIFT);
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && tc;
  assign out_data  = (MSBFIRST != 0) ? sr_q[DW-1 -: SW] : sr_q[SW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave SHIFT only on a final transfer without a follow-on word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer && tc && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register: load on accept, otherwise advance one beat per transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (accept) begin
      sr_q <= in_data;
    end else if (xfer) begin
      sr_q <= (MSBFIRST != 0) ? (sr_q << SW) : (sr_q >> SW);
    end
  end

endmodule

// File: tb/tb_la_serializer.sv
// Directed scoreboard bench for la_serializer in three configurations.
module tb_la_serializer;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    int unsigned edge_no;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_iv, a_ir, a_ov, a_ol, a_or;
  logic [7:0] a_id;
  logic [1:0] a_od;
  logic       b_iv, b_ir, b_ov, b_ol, b_or;
  logic [7:0] b_id;
  logic [1:0] b_od;
  logic       c_iv, c_ir, c_ov, c_ol, c_or;
  logic [7:0] c_id;
  logic [7:0] c_od;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];

  la_serializer #(.DW(8), .SW(2), .MSBFIRST(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_last(a_ol), .out_ready(a_or));

  la_serializer #(.DW(8), .SW(2), .MSBFIRST(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_last(b_ol), .out_ready(b_or));

  la_serializer #(.DW(8), .SW(8), .MSBFIRST(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_last(c_ol), .out_ready(c_or));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input logic [7:0] d, input logic l, input int unsigned e);
    beat_t b;
    b.data    = d;
    b.last    = l;
    b.edge_no = e;
    case (which)
      0:       qa.push_back(b);
      1:       qb.push_back(b);
      default: qc.push_back(b);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a beat is taken at the next rising edge when valid && ready.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && a_ov && a_or) begin
      if (qa.size() == 0) chk("a_beat_expected", 32'(qa.size()), 1);
      else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_od), 32'(e.data));
        chk("a_last", 32'(a_ol), 32'(e.last));
        chk("a_edge", cyc + 1, e.edge_no);
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset && b_ov && b_or) begin
      if (qb.size() == 0) chk("b_beat_expected", 32'(qb.size()), 1);
      else begin
        e = qb.pop_front();
        chk("b_data", 32'(b_od), 32'(e.data));
        chk("b_last", 32'(b_ol), 32'(e.last));
        chk("b_edge", cyc + 1, e.edge_no);
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset && c_ov && c_or) begin
      if (qc.size() == 0) chk("c_beat_expected", 32'(qc.size()), 1);
      else begin
        e = qc.pop_front();
        chk("c_data", 32'(c_od), 32'(e.data));
        chk("c_last", 32'(c_ol), 32'(e.last));
        chk("c_edge", cyc + 1, e.edge_no);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0;
    reset = 1'b1;
    a_iv = 1'b0; a_id = '0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_or = 1'b1;
    c_iv = 1'b0; c_id = '0; c_or = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_a_out_valid", 32'(a_ov), 0);
    chk("rst_a_out_data", 32'(a_od), 0);
    chk("rst_a_out_last", 32'(a_ol), 0);
    chk("rst_a_in_ready", 32'(a_ir), 0);
    chk("rst_c_out_data", 32'(c_od), 0);
    reset = 1'b0;
    #1;
    chk("rst_a_in_ready_release", 32'(a_ir), 1);
    chk("rst_c_in_ready_release", 32'(c_ir), 1);

    // LSB-first 0xB4 -> 0,1,3,2
    a_iv = 1'b1; a_id = 8'hB4; e0 = cyc + 1;
    push(0, 8'd0, 1'b0, e0 + 1);
    push(0, 8'd1, 1'b0, e0 + 2);
    push(0, 8'd3, 1'b0, e0 + 3);
    push(0, 8'd2, 1'b1, e0 + 4);
    step();
    a_iv = 1'b0; a_id = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk("t1_in_ready_busy", 32'(a_ir), 0);
      step();
    end
    chk("t1_in_ready_final", 32'(a_ir), 1);
    step();
    step();
    chk("t1_idle_valid", 32'(a_ov), 0);

    // MSB-first 0xB4 -> 2,3,1,0
    b_iv = 1'b1; b_id = 8'hB4; e0 = cyc + 1;
    push(1, 8'd2, 1'b0, e0 + 1);
    push(1, 8'd3, 1'b0, e0 + 2);
    push(1, 8'd1, 1'b0, e0 + 3);
    push(1, 8'd0, 1'b1, e0 + 4);
    step();
    b_iv = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Back-to-back 0xB4, 0x5A -> 0,1,3,2,2,2,1,1 contiguous
    a_iv = 1'b1; a_id = 8'hB4; e0 = cyc + 1;
    push(0, 8'd0, 1'b0, e0 + 1);
    push(0, 8'd1, 1'b0, e0 + 2);
    push(0, 8'd3, 1'b0, e0 + 3);
    push(0, 8'd2, 1'b1, e0 + 4);
    push(0, 8'd2, 1'b0, e0 + 5);
    push(0, 8'd2, 1'b0, e0 + 6);
    push(0, 8'd1, 1'b0, e0 + 7);
    push(0, 8'd1, 1'b1, e0 + 8);
    step();
    a_id = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      if (a_ir) break;
      step();
    end
    chk("t3_in_ready_seen", 32'(a_ir), 1);
    step();
    a_iv = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Backpressure on beat 1 for three cycles
    a_iv = 1'b1; a_id = 8'hB4; e0 = cyc + 1;
    push(0, 8'd0, 1'b0, e0 + 1);
    push(0, 8'd1, 1'b0, e0 + 5);
    push(0, 8'd3, 1'b0, e0 + 6);
    push(0, 8'd2, 1'b1, e0 + 7);
    step();
    a_iv = 1'b0;
    step();
    a_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_valid", 32'(a_ov), 1);
      chk("t4_hold_data", 32'(a_od), 1);
      chk("t4_hold_last", 32'(a_ol), 0);
      step();
    end
    a_or = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Reset after beat 1, then 0x0F -> 3,3,0,0
    a_iv = 1'b1; a_id = 8'hB4; e0 = cyc + 1;
    push(0, 8'd0, 1'b0, e0 + 1);
    push(0, 8'd1, 1'b0, e0 + 2);
    step();
    a_iv = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("t5_in_ready_in_reset", 32'(a_ir), 0);
    step();
    chk("t5_rst_valid", 32'(a_ov), 0);
    chk("t5_rst_data", 32'(a_od), 0);
    chk("t5_rst_last", 32'(a_ol), 0);
    reset = 1'b0;
    #1;
    chk("t5_in_ready_release", 32'(a_ir), 1);
    a_iv = 1'b1; a_id = 8'h0F; e0 = cyc + 1;
    push(0, 8'd3, 1'b0, e0 + 1);
    push(0, 8'd3, 1'b0, e0 + 2);
    push(0, 8'd0, 1'b0, e0 + 3);
    push(0, 8'd0, 1'b1, e0 + 4);
    step();
    a_iv = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Single-beat words 0xA5, 0x3C back-to-back
    c_iv = 1'b1; c_id = 8'hA5; e0 = cyc + 1;
    push(2, 8'hA5, 1'b1, e0 + 1);
    push(2, 8'h3C, 1'b1, e0 + 2);
    step();
    c_id = 8'h3C;
    chk("t6_in_ready_b2b", 32'(c_ir), 1);
    step();
    c_iv = 1'b0;
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      step();
    end
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    chk("qc_drained", 32'(qc.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
